sseg_scan_driver: RTL and testbench

- Consumer end of the digit-code bus produced by the clock block: eight 7-bit digit codes in, one multiplexed common-anode 7-segment display out (8 digits, active-low anodes/segments/dp).
- Snapshots all eight codes once per frame so a displayed frame never tears.
- Scans one digit per slot, with a programmable ghost-suppression blanking interval at the start of every slot.
- Sits between the clock core and the board display pins.

---
 rtl/sseg_pkg.sv | 29 ++
 rtl/sseg_glyph.sv | 13 +
 rtl/sseg_scan_driver.sv | 142 ++++++++++++++
 tb/tb_sseg_scan_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment digit-code bus and display blocks.
package sseg_pkg;

    localparam int unsigned NDIG       = 8;
    localparam int unsigned CODE_W     = 7;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned VAL_W      = 4;

    localparam int unsigned CODE_VAL_LSB   = 0;
    localparam int unsigned CODE_RSVD_BIT  = 4;
    localparam int unsigned CODE_DP_BIT    = 5;
    localparam int unsigned CODE_BLANK_BIT = 6;

    typedef struct packed {
        logic             blank;
        logic             dp;
        logic             rsvd;
        logic [VAL_W-1:0] value;
    } digit_code_t;

    localparam digit_code_t CODE_BLANK = digit_code_t'(7'h40);

    // Active-high {g,f,e,d,c,b,a}; entries 10..15 render A,P,C,d,E,F.
    localparam logic [0:15][SEG_W-1:0] GLYPH = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h73, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sseg_glyph.sv
// Combinational 4-bit value to active-high 7-segment glyph lookup.
module sseg_glyph
    import sseg_pkg::*;
(
    input  logic [VAL_W-1:0] value_i,
    output logic [SEG_W-1:0] segs_c_o
);

    always_comb begin
        segs_c_o = GLYPH[value_i];
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Frame-snapshotting 8-digit common-anode 7-segment scan driver with per-slot blanking.
// Optional SSEG_LAMP_TEST_EN adds a lamp_test input that lights every segment and dp.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned DIVIDE    = 100_000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SSEG_LAMP_TEST_EN
    input  logic              lamp_test,
`endif
    input  logic [CODE_W-1:0] d0,
    input  logic [CODE_W-1:0] d1,
    input  logic [CODE_W-1:0] d2,
    input  logic [CODE_W-1:0] d3,
    input  logic [CODE_W-1:0] d4,
    input  logic [CODE_W-1:0] d5,
    input  logic [CODE_W-1:0] d6,
    input  logic [CODE_W-1:0] d7,
    output logic [NDIG-1:0]   an_n,
    output logic [SEG_W-1:0]  segs_n,
    output logic              dp_n,
    output logic              frame_start
);

    localparam int unsigned CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam int unsigned IDX_W = $clog2(NDIG);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    digit_code_t      snap_q [NDIG];
    digit_code_t      snap_d [NDIG];
    digit_code_t      din    [NDIG];
    logic [NDIG-1:0]  an_q, an_d;
    logic [SEG_W-1:0] segs_q, segs_d;
    logic             dp_q, dp_d;
    logic             fs_q, fs_d;

    logic             slot_end;
    logic             frame_head;
    logic             in_blank;
    logic             lamp;
    digit_code_t      code;
    logic [SEG_W-1:0] glyph;
    logic             unused_rsvd;

    always_comb begin
        din[0] = digit_code_t'(d0);
        din[1] = digit_code_t'(d1);
        din[2] = digit_code_t'(d2);
        din[3] = digit_code_t'(d3);
        din[4] = digit_code_t'(d4);
        din[5] = digit_code_t'(d5);
        din[6] = digit_code_t'(d6);
        din[7] = digit_code_t'(d7);
    end

`ifdef SSEG_LAMP_TEST_EN
    assign lamp = lamp_test;
`else
    assign lamp = 1'b0;
`endif

    assign slot_end   = (cnt_q == CNT_W'(DIVIDE - 1));
    assign frame_head = (cnt_q == '0) && (idx_q == '0);
    assign in_blank   = (cnt_q < CNT_W'(BLANK_CYC));
    assign code       = snap_q[idx_q];

    sseg_glyph u_glyph (
        .value_i  (code.value),
        .segs_c_o (glyph)
    );

    // The reserved field rides along in the snapshot but never reaches a pin.
    always_comb begin
        unused_rsvd = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            unused_rsvd = unused_rsvd ^ snap_q[k].rsvd;
        end
    end

    always_comb begin
        cnt_d  = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d  = slot_end ? idx_q + IDX_W'(1) : idx_q;
        snap_d = snap_q;
        an_d   = '1;
        segs_d = '1;
        dp_d   = 1'b1;
        fs_d   = frame_head;

        if (frame_head) begin
            for (int k = 0; k < NDIG; k++) begin
                snap_d[k] = din[k];
            end
        end

        // Lamp test overrides the blank bit but still honours the blanking interval.
        if (!in_blank) begin
            if (lamp) begin
                an_d   = ~(NDIG'(1) << idx_q);
                segs_d = '0;
                dp_d   = 1'b0;
            end else if (!code.blank) begin
                an_d   = ~(NDIG'(1) << idx_q);
                segs_d = ~glyph;
                dp_d   = ~code.dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            segs_q <= '1;
            dp_q   <= 1'b1;
            fs_q   <= 1'b0;
            for (int k = 0; k < NDIG; k++) begin
                snap_q[k] <= CODE_BLANK;
            end
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            segs_q <= segs_d;
            dp_q   <= dp_d;
            fs_q   <= fs_d;
            for (int k = 0; k < NDIG; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    assign an_n        = an_q;
    assign segs_n      = segs_q;
    assign dp_n        = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver at DIVIDE=8, BLANK_CYC=2 (64-cycle frame).
module tb_sseg_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 8 * DIV;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] segs;
        logic       dp;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lamp_test = 1'b0;
    logic [6:0] d [8];
    logic [7:0] an_n;
    logic [6:0] segs_n;
    logic       dp_n;
    logic       frame_start;

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    int         m_cnt = 0;
    int         m_idx = 0;
    logic [6:0] m_snap [8];

    int cyc     = 0;
    int last_fs = -1;
    int an7_hits = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.DIVIDE(DIV), .BLANK_CYC(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SSEG_LAMP_TEST_EN
        .lamp_test   (lamp_test),
`endif
        .d0          (d[0]),
        .d1          (d[1]),
        .d2          (d[2]),
        .d3          (d[3]),
        .d4          (d[4]),
        .d5          (d[5]),
        .d6          (d[6]),
        .d7          (d[7]),
        .an_n        (an_n),
        .segs_n      (segs_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        case (v)
            4'd0:  return 7'h3F;  4'd1:  return 7'h06;
            4'd2:  return 7'h5B;  4'd3:  return 7'h4F;
            4'd4:  return 7'h66;  4'd5:  return 7'h6D;
            4'd6:  return 7'h7D;  4'd7:  return 7'h07;
            4'd8:  return 7'h7F;  4'd9:  return 7'h6F;
            4'd10: return 7'h77;  4'd11: return 7'h73;
            4'd12: return 7'h39;  4'd13: return 7'h5E;
            4'd14: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Model one clock edge: push the output the DUT must show after it, then sample and compare.
    task automatic step();
        exp_t       e;
        exp_t       o;
        logic [6:0] code;
        logic       was_rst;
        e       = '{an: 8'hFF, segs: 7'h7F, dp: 1'b1, fs: 1'b0};
        was_rst = !rst;
        if (!rst) begin
            m_cnt = 0;
            m_idx = 0;
            for (int k = 0; k < 8; k++) m_snap[k] = 7'h40;
        end else begin
            e.fs = (m_cnt == 0) && (m_idx == 0);
            code = m_snap[m_idx];
            if (m_cnt >= BLANK) begin
                if (lamp_test) begin
                    e.an = ~(8'h01 << m_idx);
                    e.segs = 7'h00;
                    e.dp = 1'b0;
                end else if (!code[6]) begin
                    e.an   = ~(8'h01 << m_idx);
                    e.segs = ~ref_glyph(code[3:0]);
                    e.dp   = ~code[5];
                end
            end
            if (m_cnt == 0 && m_idx == 0) begin
                for (int k = 0; k < 8; k++) m_snap[k] = d[k];
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        o = exp_q.pop_front();
        check_eq("an_n",        32'(an_n),        32'(o.an));
        check_eq("segs_n",      32'(segs_n),      32'(o.segs));
        check_eq("dp_n",        32'(dp_n),        32'(o.dp));
        check_eq("frame_start", 32'(frame_start), 32'(o.fs));
        if (an_n == 8'h7F) an7_hits++;
        if (was_rst) begin
            last_fs = -1;
        end else if (frame_start === 1'b1) begin
            if (last_fs >= 0) check_eq("fs_period", 32'(cyc - last_fs), 32'(FRAME));
            last_fs = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_slot(input int slot);
        for (int i = 0; i < FRAME && !(m_idx == slot && m_cnt == 0); i++) step();
        check_eq("reach_slot", 32'(m_idx), 32'(slot));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) m_snap[k] = 7'h40;

        // Reset held with arbitrary codes
        rst = 1'b0;
        for (int k = 0; k < 8; k++) d[k] = 7'($urandom_range(0, 127));
        run(5);

        // Scan order: '1' on digit 0, '8' elsewhere
        d[0] = 7'h01;
        for (int k = 1; k < 8; k++) d[k] = 7'h08;
        rst = 1'b1;
        run(2 * FRAME);

        // Blank digit 7, digit 1 shows 5 with dp
        d[7] = 7'h40;
        d[1] = 7'h25;
        run(FRAME);
        an7_hits = 0;
        run(FRAME);
        check_eq("an7_never_lit", 32'(an7_hits), 32'd0);

        // A then P on digit 6
        d[6] = 7'h0A;
        run(2 * FRAME);
        d[6] = 7'h0B;
        run(2 * FRAME);

        // Input change mid-frame must wait for the next snapshot
        run_to_slot(3);
        d[0] = 7'h02;
        run(2 * FRAME);

        // Reset pulse during slot 4
        run_to_slot(4);
        run(3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        d[2] = 7'h3E;
        run(2 * FRAME);

`ifdef SSEG_LAMP_TEST_EN
        lamp_test = 1'b1;
        run(FRAME);
        lamp_test = 1'b0;
        run(FRAME);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
